program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised program counter with a built-in hardware return stack, successor to the basic load/increment counter in the CPU front end. Computes the next fetch address each cycle from one of five commands: increment, absolute load, PC-relative branch, call and return. Sits between the control unit (command strobes) and instruction memory (address). Reports stack depth and sticky overflow/underflow status for debug and trap logic.

## Interface
- WIDTH, 11, MSB index of the PC; all address buses are WIDTH+1 bits wide.
- STACK_DEPTH, 4, number of return-stack entries (≥1).
- RESET_VECTOR, 0, PC value loaded on reset.
- STEP, 1, increment amount for inc and for the call return address.
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- inc_pc  in  1  advance PC by STEP.
- load_pc  in  1  absolute jump to pc_val.
- branch_pc  in  1  relative jump, PC + sign-extended pc_offset.
- call_pc  in  1  push PC+STEP, jump to pc_val.
- ret_pc  in  1  pop top of stack into PC.
- pc_val  in  WIDTH+1  absolute target for load/call.
- pc_offset  in  WIDTH+1  two's-complement branch offset.
- pc  out  WIDTH+1  current PC, registered.
- depth  out  clog2(STACK_DEPTH+1)  entries currently on stack.
- stack_full  out  1  depth == STACK_DEPTH, combinational from depth.
- stack_ovf  out  1  sticky, call attempted while full.
- stack_unf  out  1  sticky, ret attempted while empty.

## Operation
- Command priority, highest first: ret_pc, call_pc, branch_pc, load_pc, inc_pc; lower commands in the same cycle are ignored. No command: PC holds.
- inc: pc <= pc + STEP.
- load: pc <= pc_val.
- branch: pc <= pc + pc_offset; offset is already full width, treated as signed.
- call: push (pc + STEP), pc <= pc_val, depth +1.
- ret: pc <= top entry, depth −1.
- All arithmetic modulo 2^(WIDTH+1); carries discarded, wrap-around silent (max + 1 → 0, 0 − 1 → max).
- Call while full: jump still taken, push dropped, depth unchanged, stack_ovf set.
- Ret while empty: PC holds, depth stays 0, stack_ovf unaffected, stack_unf set.
- stack_ovf/stack_unf cleared only by reset.
- Stack contents beyond depth are don't-care; no read-before-write hazard since push and pop never coincide (priority).

## Timing
- Reset (rst low at rising edge): pc = RESET_VECTOR, depth = 0, stack_full = 0, stack_ovf = 0, stack_unf = 0; all commands in that cycle ignored. Mid-operation reset discards stack contents.
- Latency: command sampled at edge N, new pc visible after edge N (one cycle); pc never changes combinationally from inputs.
- Commands are level-sampled every cycle; holding inc_pc high advances STEP per cycle.
- depth and flags update on the same edge as pc.
- Back-to-back call/ret in consecutive cycles fully supported, one per cycle.

## Configuration
- Macro PROGRAM_SEQUENCER_STACK_EN.
- Defined: return stack, call/ret, depth and flag outputs as above.
- Undefined: no stack storage; call_pc behaves as load_pc (jump to pc_val, no push); ret_pc ignored (treated as no command, priority falls to lower commands); depth, stack_full, stack_ovf, stack_unf tied to 0.

## Structure
- Package program_sequencer_pkg: command-select encoding constants (CMD_NONE, CMD_INC, CMD_LOAD, CMD_BRANCH, CMD_CALL, CMD_RET) and the priority-encoder function mapping strobes to a command.
- Sub-module pc_return_stack: LIFO of STACK_DEPTH × (WIDTH+1), push/pop/top/depth/full/empty, overflow and underflow pulses; instantiated only under PROGRAM_SEQUENCER_STACK_EN.
- Top level: priority decode, next-PC mux/adder, PC register, sticky flags.

## Test plan
Defaults WIDTH=11, STACK_DEPTH=4, RESET_VECTOR=0, STEP=1.
- Reset, then inc_pc high 4 cycles → pc = 4.
- load_pc with pc_val=261 and inc_pc also high → pc = 261 next cycle, stays 261 while load held.
- At pc=261 branch_pc, pc_offset=12'hFFB → pc = 256; at pc=12'hFFF inc_pc → pc = 0.
- At pc=10 call_pc, pc_val=256 → pc = 256, depth = 1; then ret_pc → pc = 11, depth = 0; call_pc+ret_pc together at pc=11 → ret wins, pc holds 11, stack_unf = 1.
- Five consecutive calls → depth = 4, stack_full = 1, stack_ovf = 1, pc = last target; four rets unwind in LIFO order; fifth ret → pc holds, stack_unf = 1.
- depth = 3, assert rst low with call_pc high → next cycle pc = 0, depth = 0, all flags 0; rebuild without macro: call → pc = pc_val, depth stays 0, ret → no change.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Command encoding and strobe priority decode shared by the program sequencer.
// Optional return stack is enabled by defining PROGRAM_SEQUENCER_STACK_EN.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_INC    = 3'd1,
    CMD_LOAD   = 3'd2,
    CMD_BRANCH = 3'd3,
    CMD_CALL   = 3'd4,
    CMD_RET    = 3'd5
  } cmd_e;

  // ret > call > branch > load > inc; without a stack ret vanishes and call degrades to load
  function automatic cmd_e decode_cmd(
    input logic inc,
    input logic load,
    input logic branch,
    input logic call,
    input logic ret,
    input logic stack_en
  );
    cmd_e cmd;
    cmd = CMD_NONE;
    if (stack_en && ret)  cmd = CMD_RET;
    else if (call)        cmd = stack_en ? CMD_CALL : CMD_LOAD;
    else if (branch)      cmd = CMD_BRANCH;
    else if (load)        cmd = CMD_LOAD;
    else if (inc)         cmd = CMD_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with depth tracking; pushes when full and pops when
// empty are dropped and reported as single-cycle pulses.
module pc_return_stack #(
  parameter int WIDTH       = 11,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH:0]   push_data,
  output logic [WIDTH:0]   top_data,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_pulse,
  output logic             unf_pulse
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DW-1:0]  depth_reg, depth_next;
  logic [WIDTH:0] entries [STACK_DEPTH];
  logic [AW-1:0]  top_idx;
  logic           do_push, do_pop;

  assign full      = (depth_reg == DW'(STACK_DEPTH));
  assign empty     = (depth_reg == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign ovf_pulse = push && full;
  assign unf_pulse = pop && empty;
  assign depth     = depth_reg;

  always_comb begin
    depth_next = depth_reg;
    if (do_push)     depth_next = depth_reg + DW'(1);
    else if (do_pop) depth_next = depth_reg - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) depth_reg <= '0;
    else      depth_reg <= depth_next;
  end

  // Entry gi is written only by the push that makes depth gi+1; contents need no reset
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
    logic [WIDTH:0] entry_reg;
    always_ff @(posedge clk) begin
      if (rst && do_push && depth_reg == DW'(gi)) entry_reg <= push_data;
    end
    assign entries[gi] = entry_reg;
  end

  assign top_idx  = AW'(depth_reg - DW'(1));
  assign top_data = entries[top_idx];

endmodule

// File: rtl/program_sequencer.sv
// Program counter with inc/load/branch/call/ret commands and optional return
// stack (PROGRAM_SEQUENCER_STACK_EN); synchronous active-low reset.
module program_sequencer #(
  parameter int WIDTH        = 11,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0,
  parameter int STEP         = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inc_pc,
  input  logic                             load_pc,
  input  logic                             branch_pc,
  input  logic                             call_pc,
  input  logic                             ret_pc,
  input  logic [WIDTH:0]                   pc_val,
  input  logic [WIDTH:0]                   pc_offset,
  output logic [WIDTH:0]                   pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_full,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  import program_sequencer_pkg::*;

  localparam int PW = WIDTH + 1;
  localparam int DW = $clog2(STACK_DEPTH + 1);
`ifdef PROGRAM_SEQUENCER_STACK_EN
  localparam logic STACK_EN = 1'b1;
`else
  localparam logic STACK_EN = 1'b0;
`endif

  cmd_e           cmd;
  logic [WIDTH:0] pc_reg, pc_next, stack_top;
  logic           stack_empty;

  assign cmd = decode_cmd(inc_pc, load_pc, branch_pc, call_pc, ret_pc, STACK_EN);

  always_comb begin
    pc_next = pc_reg;
    case (cmd)
      CMD_INC:    pc_next = pc_reg + PW'(STEP);
      CMD_LOAD:   pc_next = pc_val;
      CMD_BRANCH: pc_next = pc_reg + pc_offset;
      CMD_CALL:   pc_next = pc_val;
      CMD_RET:    pc_next = stack_empty ? pc_reg : stack_top;
      default:    pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_reg <= PW'(RESET_VECTOR);
    else      pc_reg <= pc_next;
  end

  assign pc = pc_reg;

`ifdef PROGRAM_SEQUENCER_STACK_EN
  logic          ovf_pulse, unf_pulse, ovf_reg, unf_reg, full_int;
  logic [DW-1:0] depth_int;

  pc_return_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd == CMD_CALL),
    .pop       (cmd == CMD_RET),
    .push_data (pc_reg + PW'(STEP)),
    .top_data  (stack_top),
    .depth     (depth_int),
    .full      (full_int),
    .empty     (stack_empty),
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | ovf_pulse;
      unf_reg <= unf_reg | unf_pulse;
    end
  end

  assign depth      = depth_int;
  assign stack_full = full_int;
  assign stack_ovf  = ovf_reg;
  assign stack_unf  = unf_reg;
`else
  assign stack_top   = '0;
  assign stack_empty = 1'b1;
  assign depth       = '0;
  assign stack_full  = 1'b0;
  assign stack_ovf   = 1'b0;
  assign stack_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: directed walk-through plus randomized commands against a
// queue-based reference model; follows PROGRAM_SEQUENCER_STACK_EN like the DUT.
module tb_program_sequencer;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, inc_pc, load_pc, branch_pc, call_pc, ret_pc;
  logic [11:0] pc_val, pc_offset, pc;
  logic [2:0]  depth;
  logic        stack_full, stack_ovf, stack_unf;

  always #5 clk = ~clk;

  program_sequencer #(
    .WIDTH(11), .STACK_DEPTH(SD), .RESET_VECTOR(0), .STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .inc_pc(inc_pc), .load_pc(load_pc),
    .branch_pc(branch_pc), .call_pc(call_pc), .ret_pc(ret_pc),
    .pc_val(pc_val), .pc_offset(pc_offset), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  logic [11:0] m_pc;
  logic [11:0] m_stk[$];
  bit          m_ovf, m_unf;
  int          n_cmp = 0, n_err = 0, n_txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference behaviour: one command per cycle, stack as a plain queue
  task automatic model_step(input logic r_n, i, l, b, c, rt, input logic [11:0] v, o);
    if (!r_n) begin
      m_pc = 12'd0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end
`ifdef PROGRAM_SEQUENCER_STACK_EN
    else if (rt) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_pc = m_stk.pop_back();
    end else if (c) begin
      if (m_stk.size() < SD) m_stk.push_back(m_pc + 12'd1);
      else m_ovf = 1;
      m_pc = v;
    end
`else
    else if (c) m_pc = v;
`endif
    else if (b) m_pc = m_pc + o;
    else if (l) m_pc = v;
    else if (i) m_pc = m_pc + 12'd1;
  endtask

  task automatic cycle(input logic r_n, i, l, b, c, rt, input logic [11:0] v, o);
    rst = r_n; inc_pc = i; load_pc = l; branch_pc = b; call_pc = c; ret_pc = rt;
    pc_val = v; pc_offset = o;
    @(posedge clk);
    model_step(r_n, i, l, b, c, rt, v, o);
    #1;
    n_txn++;
    $display("txn %0d rst=%b i/l/b/c/r=%b%b%b%b%b val=%h off=%h -> pc=%h depth=%0d full=%b ovf=%b unf=%b",
             n_txn, r_n, i, l, b, c, rt, v, o, pc, depth, stack_full, stack_ovf, stack_unf);
    check("pc", 32'(pc), 32'(m_pc));
    check("depth", 32'(depth), 32'(m_stk.size()));
    check("full", 32'(stack_full), 32'(m_stk.size() == SD));
    check("ovf", 32'(stack_ovf), 32'(m_ovf));
    check("unf", 32'(stack_unf), 32'(m_unf));
  endtask

  initial begin
    rst = 1'b0; inc_pc = 0; load_pc = 0; branch_pc = 0; call_pc = 0; ret_pc = 0;
    pc_val = '0; pc_offset = '0;
    m_pc = 12'd0; m_ovf = 0; m_unf = 0;

    cycle(0, 0, 0, 0, 0, 0, 12'd0, 12'd0);
    cycle(0, 1, 0, 0, 0, 0, 12'd0, 12'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);

    repeat (4) cycle(1, 1, 0, 0, 0, 0, 12'd0, 12'd0);
    check("inc4", 32'(pc), 32'd4);
    cycle(1, 1, 1, 0, 0, 0, 12'd261, 12'd0);
    check("load261", 32'(pc), 32'd261);
    cycle(1, 0, 1, 0, 0, 0, 12'd261, 12'd0);
    check("load_hold", 32'(pc), 32'd261);
    cycle(1, 0, 0, 1, 0, 0, 12'd0, 12'hFFB);
    check("branch_neg", 32'(pc), 32'd256);
    cycle(1, 0, 1, 0, 0, 0, 12'hFFF, 12'd0);
    cycle(1, 1, 0, 0, 0, 0, 12'd0, 12'd0);
    check("inc_wrap", 32'(pc), 32'd0);
    cycle(1, 0, 1, 0, 0, 0, 12'd10, 12'd0);

`ifdef PROGRAM_SEQUENCER_STACK_EN
    cycle(1, 0, 0, 0, 1, 0, 12'd256, 12'd0);
    check("call_pc", 32'(pc), 32'd256);
    check("call_depth", 32'(depth), 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 12'd0, 12'd0);
    check("ret_pc", 32'(pc), 32'd11);
    check("ret_depth", 32'(depth), 32'd0);
    cycle(1, 0, 0, 0, 1, 1, 12'd500, 12'd0);
    check("callret_pc", 32'(pc), 32'd11);
    check("callret_unf", 32'(stack_unf), 32'd1);
    for (int k = 1; k <= 5; k++) cycle(1, 0, 0, 0, 1, 0, 12'(100 * k), 12'd0);
    check("calls_depth", 32'(depth), 32'd4);
    check("calls_full", 32'(stack_full), 32'd1);
    check("calls_ovf", 32'(stack_ovf), 32'd1);
    check("calls_pc", 32'(pc), 32'd500);
    begin
      int exp_ret[4] = '{301, 201, 101, 12};
      for (int k = 0; k < 4; k++) begin
        cycle(1, 0, 0, 0, 0, 1, 12'd0, 12'd0);
        check("lifo_pc", 32'(pc), 32'(exp_ret[k]));
      end
    end
    cycle(1, 0, 0, 0, 0, 1, 12'd0, 12'd0);
    check("ret_empty_pc", 32'(pc), 32'd12);
    check("ret_empty_unf", 32'(stack_unf), 32'd1);
    repeat (3) cycle(1, 0, 0, 0, 1, 0, 12'd77, 12'd0);
    check("pre_rst_depth", 32'(depth), 32'd3);
`else
    cycle(1, 0, 0, 0, 1, 0, 12'd256, 12'd0);
    check("nostk_call_pc", 32'(pc), 32'd256);
    check("nostk_call_depth", 32'(depth), 32'd0);
    cycle(1, 0, 0, 0, 0, 1, 12'd0, 12'd0);
    check("nostk_ret_pc", 32'(pc), 32'd256);
    cycle(1, 0, 0, 0, 1, 1, 12'd500, 12'd0);
    check("nostk_callret", 32'(pc), 32'd500);
    cycle(1, 1, 0, 0, 0, 1, 12'd0, 12'd0);
    check("nostk_retinc", 32'(pc), 32'd501);
`endif
    cycle(0, 0, 0, 0, 1, 0, 12'd99, 12'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_depth", 32'(depth), 32'd0);
    check("midrst_ovf", 32'(stack_ovf), 32'd0);
    check("midrst_unf", 32'(stack_unf), 32'd0);

    for (int n = 0; n < 400; n++) begin
      cycle(logic'($urandom_range(0, 59) != 0),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 4) == 0),
            logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 2) == 0),
            12'($urandom), 12'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
